mem_initiator: RTL and testbench

Multicycle-datapath master for the 32x16 single-port data memory. It accepts single load/store requests and LM/SM-style multiple transfers (8-bit register mask). It sequences them as one memory access per clock at consecutive addresses, driving the memory's active-low read/write strobes and returning read data tagged with the register index. It sits between the control FSM/register file and the memory, so the datapath never drives memory strobes directly.

---
 rtl/mem_initiator.sv | 177 +++++++++++++++++
 tb/tb_mem_initiator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : mem_initiator
//  Purpose  : Memory master for the 32x16 single-port data memory. Accepts a
//             single load/store or an LM/SM-style multiple transfer selected
//             by an 8-bit register mask, and issues one access per clock at
//             consecutive (mod-32) addresses with registered active-low
//             strobes. Load data comes back tagged with its register index.
//  Ports    : clk, rst_n (async, active-low)
//             req, op_write, multi, base_addr[4:0], reg_mask[7:0], wdata[15:0]
//                 request side from control FSM / register file
//             busy, done, reg_idx[2:0], rdata[15:0], rdata_idx[2:0],
//             rdata_valid
//                 status and load-return side
//             mem_address[4:0], mem_in[15:0], mem_write, mem_read, mem_out[15:0]
//                 memory side (memory samples on the falling clock edge)
//  Revision : 1.0  initial release
// ============================================================================
module mem_initiator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        op_write,
    input  logic        multi,
    input  logic [4:0]  base_addr,
    input  logic [7:0]  reg_mask,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic [2:0]  reg_idx,
    output logic [15:0] rdata,
    output logic [2:0]  rdata_idx,
    output logic        rdata_valid,
    output logic        done,
    output logic [4:0]  mem_address,
    output logic [15:0] mem_in,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [15:0] mem_out
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_TAIL = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        op_q, op_d;
    logic [4:0]  addr_q, addr_d;
    logic [7:0]  mask_q, mask_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [15:0] rdata_q;
    logic [2:0]  rdata_idx_q;
    logic        rdata_valid_q;

    logic        w_req_accept;
    logic [7:0]  w_req_mask;
    logic [2:0]  w_low_idx;
    logic [7:0]  w_low_onehot;
    logic [7:0]  w_mask_left;
    logic        w_load_beat;

    // A single transfer is just a multiple transfer of register 0.
    assign w_req_mask   = multi ? reg_mask : 8'h01;
    assign w_req_accept = (state_q == c_IDLE) && req;

    // Lowest set bit of the remaining mask: the register served this cycle.
    assign w_low_onehot = mask_q & (~mask_q + 8'd1);
    assign w_mask_left  = mask_q & ~w_low_onehot;

    always_comb begin
        w_low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) begin
                w_low_idx = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (req) begin
                    state_d = (w_req_mask != 8'h00) ? c_RUN : c_TAIL;
                end
            end
            c_RUN: begin
                if (w_mask_left == 8'h00) begin
                    state_d = c_TAIL;
                end
            end
            c_TAIL:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q != c_IDLE);
        done = (state_q == c_TAIL);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        op_d   = op_q;
        addr_d = addr_q;
        mask_d = mask_q;
        if (w_req_accept) begin
            op_d   = op_write;
            addr_d = base_addr;
            mask_d = w_req_mask;
        end else if (state_q == c_RUN) begin
            addr_d = addr_q + 5'd1;
            mask_d = w_mask_left;
        end
        // Strobes are registered from the next state so that they are
        // stable a full half cycle before the memory's falling-edge sample.
        mem_read_d  = !((state_d == c_RUN) && !op_d);
        mem_write_d = !((state_d == c_RUN) &&  op_d);
    end

    // A read strobe in this cycle means mem_out is valid at the next edge.
    assign w_load_beat = (state_q == c_RUN) && !op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= 1'b0;
            addr_q        <= 5'd0;
            mask_q        <= 8'h00;
            mem_read_q    <= 1'b1;
            mem_write_q   <= 1'b1;
            rdata_q       <= 16'h0000;
            rdata_idx_q   <= 3'd0;
            rdata_valid_q <= 1'b0;
        end else begin
            op_q          <= op_d;
            addr_q        <= addr_d;
            mask_q        <= mask_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            rdata_valid_q <= w_load_beat;
            if (w_load_beat) begin
                rdata_q     <= mem_out;
                rdata_idx_q <= w_low_idx;
            end
        end
    end

    assign reg_idx     = w_low_idx;
    assign mem_address = addr_q;
    assign mem_in      = wdata;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign rdata       = rdata_q;
    assign rdata_idx   = rdata_idx_q;
    assign rdata_valid = rdata_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_initiator
//  Purpose  : Self-checking bench for mem_initiator. Contains a falling-edge
//             32x16 memory model, a register file feeding wdata, a table of
//             directed transfers, hand-written reset/guard sequences and a
//             randomized phase checked against a transfer-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        op_write;
    logic        multi;
    logic [4:0]  base_addr;
    logic [7:0]  reg_mask;
    logic [15:0] wdata;
    logic        busy;
    logic [2:0]  reg_idx;
    logic [15:0] rdata;
    logic [2:0]  rdata_idx;
    logic        rdata_valid;
    logic        done;
    logic [4:0]  mem_address;
    logic [15:0] mem_in;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_out = 16'h0000;

    mem_initiator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .op_write    (op_write),
        .multi       (multi),
        .base_addr   (base_addr),
        .reg_mask    (reg_mask),
        .wdata       (wdata),
        .busy        (busy),
        .reg_idx     (reg_idx),
        .rdata       (rdata),
        .rdata_idx   (rdata_idx),
        .rdata_valid (rdata_valid),
        .done        (done),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_out     (mem_out)
    );

    always #5 clk = ~clk;

    // Register file: combinational read port addressed by reg_idx.
    logic [15:0] rf [8];
    assign wdata = rf[reg_idx];

    // Memory model: samples address/strobes/data on the falling edge.
    logic [15:0] mem [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = 5'd0;
    logic [15:0] pre_data = 16'h0000;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    always @(negedge clk) begin
        if (pre_we)     mem[pre_addr] <= pre_data;
        if (!mem_write) begin
            mem[mem_address] <= mem_in;
            wr_cnt <= wr_cnt + 1;
        end
        if (!mem_read) begin
            mem_out <= mem[mem_address];
            rd_cnt  <= rd_cnt + 1;
        end
    end

    // Reference memory contents as the transfer model expects them.
    logic [15:0] ref_mem [32];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        #1;
        pre_we     = 1'b0;
        ref_mem[a] = d;
    endtask

    // One complete transfer. The model expands the effective mask into the
    // ordered list of registers, then checks every cycle from the first
    // access through the first idle cycle. glitch=c pulses req in cycle c.
    task automatic run_txn(input logic op, input logic mul, input logic [4:0] base,
                           input logic [7:0] mask, input int glitch, input int exp_acc);
        logic [7:0] m;
        int         regs[$];
        int         n;
        int         rd0;
        int         wr0;
        logic [4:0] a;
        logic       acc;
        m = mul ? mask : 8'h01;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) regs.push_back(i);
        end
        n   = regs.size();
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        op_write  = op;
        multi     = mul;
        base_addr = base;
        reg_mask  = mask;
        req       = 1'b1;
        tick();
        req = 1'b0;
        // Request inputs are latched; scramble them to prove it.
        op_write  = 1'($urandom);
        multi     = 1'($urandom);
        base_addr = 5'($urandom);
        reg_mask  = 8'($urandom);
        for (int c = 1; c <= n + 1; c++) begin
            acc = (c <= n);
            chk("busy", busy, 1);
            chk("done", done, (c == n + 1));
            chk("mem_read", mem_read, !(acc && !op));
            chk("mem_write", mem_write, !(acc && op));
            chk("rdata_valid", rdata_valid, (!op && c >= 2));
            if (!op && c >= 2) begin
                a = base + 5'(c - 2);
                chk("rdata", rdata, ref_mem[a]);
                chk("rdata_idx", rdata_idx, regs[c - 2]);
            end
            if (acc) begin
                a = base + 5'(c - 1);
                chk("mem_address", mem_address, a);
                chk("reg_idx", reg_idx, regs[c - 1]);
                if (op) ref_mem[a] = rf[regs[c - 1]];
            end
            if (glitch == c && acc) begin
                req = 1'b1;
                tick();
                req = 1'b0;
            end else begin
                tick();
            end
        end
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("rdata_valid_after", rdata_valid, 0);
        chk("strobe_count", op ? (wr_cnt - wr0) : (rd_cnt - rd0), exp_acc);
        chk("other_strobe_count", op ? (rd_cnt - rd0) : (wr_cnt - wr0), 0);
    endtask

    typedef struct {
        logic        op;
        logic        mul;
        logic [4:0]  base;
        logic [7:0]  mask;
        logic        pre_en;
        logic [4:0]  pre_a;
        logic [15:0] pre_d;
        int          glitch;
        int          exp_acc;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int rd0;
        logic        r_op;
        logic        r_mul;
        logic [7:0]  r_mask;
        rst_n     = 1'b0;
        req       = 1'b0;
        op_write  = 1'b0;
        multi     = 1'b0;
        base_addr = 5'd0;
        reg_mask  = 8'h00;
        rf[0] = 16'h1234;
        for (int i = 1; i < 8; i++) rf[i] = 16'hC0D0 + 16'(i);

        //            op    mul   base    mask   pre   pre_a  pre_d     gl acc
        tbl[0] = '{1'b0, 1'b1, 5'd0,  8'hFF, 1'b0, 5'd0, 16'h0000, 3, 8};
        tbl[1] = '{1'b0, 1'b0, 5'd5,  8'h00, 1'b1, 5'd5, 16'hBEEF, 0, 1};
        tbl[2] = '{1'b1, 1'b0, 5'd9,  8'h00, 1'b0, 5'd0, 16'h0000, 0, 1};
        tbl[3] = '{1'b0, 1'b0, 5'd9,  8'h00, 1'b0, 5'd0, 16'h0000, 0, 1};
        tbl[4] = '{1'b1, 1'b1, 5'd30, 8'hA5, 1'b0, 5'd0, 16'h0000, 2, 4};
        tbl[5] = '{1'b0, 1'b1, 5'd7,  8'h00, 1'b0, 5'd0, 16'h0000, 0, 0};
        tbl[6] = '{1'b1, 1'b1, 5'd12, 8'h00, 1'b0, 5'd0, 16'h0000, 0, 0};
        tbl[7] = '{1'b0, 1'b0, 5'd31, 8'hF0, 1'b0, 5'd0, 16'h0000, 0, 1};
        tbl[8] = '{1'b1, 1'b1, 5'd31, 8'h80, 1'b0, 5'd0, 16'h0000, 0, 1};
        tbl[9] = '{1'b0, 1'b1, 5'd30, 8'hA5, 1'b0, 5'd0, 16'h0000, 1, 4};

        for (int a = 0; a < 32; a++) preload(5'(a), 16'h0100 + 16'(a));

        // Reset values
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_rdata_idx", rdata_idx, 0);
        chk("rst_reg_idx", reg_idx, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_write", mem_write, 1);
        chk("rst_mem_read", mem_read, 1);
        rst_n = 1'b1;
        tick();

        // Directed table
        for (int k = 0; k < 10; k++) begin
            if (tbl[k].pre_en) preload(tbl[k].pre_a, tbl[k].pre_d);
            run_txn(tbl[k].op, tbl[k].mul, tbl[k].base, tbl[k].mask,
                    tbl[k].glitch, tbl[k].exp_acc);
            if (k == 1) chk("single_load_beef", rdata, 16'hBEEF);
            if (k == 3) chk("store_then_load", rdata, 16'h1234);
        end

        // Reset in cycle 3 of an 8-word load
        rd0       = rd_cnt;
        op_write  = 1'b0;
        multi     = 1'b1;
        base_addr = 5'd0;
        reg_mask  = 8'hFF;
        req       = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("abort_pre_read", mem_read, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_mem_read", mem_read, 1);
        chk("abort_mem_write", mem_write, 1);
        chk("abort_done", done, 0);
        chk("abort_rdata_valid", rdata_valid, 0);
        tick();
        chk("abort_done_hold", done, 0);
        chk("abort_busy_hold", busy, 0);
        chk("abort_reads", rd_cnt - rd0, 2);
        rst_n = 1'b1;
        tick();
        run_txn(1'b0, 1'b0, 5'd3, 8'h00, 0, 1);

        // Randomized transfers
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
            r_op   = 1'($urandom);
            r_mul  = ($urandom_range(0, 3) != 0);
            r_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_txn(r_op, r_mul, 5'($urandom), r_mask, int'($urandom_range(0, 8)),
                    r_mul ? $countones(r_mask) : 1);
        end

        // Memory contents after all stores
        for (int a = 0; a < 32; a++) chk("mem_contents", mem[a], ref_mem[a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
